// File: rtl/shift_rotate_unit.sv
// Multi-cycle shift/rotate execution unit. Each RUN cycle moves the working
// value by up to STEP bit positions until the requested count is used up. A
// start/busy/done handshake lets the control unit stall until the result is
// valid.
module shift_rotate_unit #(
    parameter int WIDTH = 32,
    parameter int STEP  = 4,
    parameter int AW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] operand,
    input  logic [AW-1:0]    amount,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out
);

    localparam logic [2:0] OP_SHL  = 3'b000;
    localparam logic [2:0] OP_SHR  = 3'b001;
    localparam logic [2:0] OP_SHRA = 3'b010;
    localparam logic [2:0] OP_ROL  = 3'b011;
    localparam logic [2:0] OP_ROR  = 3'b100;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [AW-1:0]    rem;
    logic [2:0]       op_q;
    logic             carry_q;

    int               step_n;
    logic [WIDTH:0]   step_next;

    // Move value a by s positions (1 <= s < WIDTH); returns {carry, value},
    // where carry is the last bit to leave the value.
    function automatic logic [WIDTH:0] shift_by(input logic [WIDTH-1:0] a,
                                                input logic [2:0]       o,
                                                input int               s);
        logic [WIDTH:0]        wide;
        logic signed [WIDTH:0] swide;
        logic [WIDTH-1:0]      v;
        wide  = '0;
        swide = '0;
        v     = '0;
        case (o)
            OP_SHL: begin
                // The bit just above the top after shifting is the last one out.
                wide = {1'b0, a} << s;
            end
            OP_SHR: begin
                // A guard bit below bit 0 catches the last bit out.
                v    = '0;
                wide = {a, 1'b0} >> s;
                wide = {wide[0], wide[WIDTH:1]};
            end
            OP_SHRA: begin
                swide = $signed({a, 1'b0}) >>> s;
                wide  = {swide[0], swide[WIDTH:1]};
            end
            OP_ROL: begin
                v    = (a << s) | (a >> (WIDTH - s));
                wide = {v[0], v};
            end
            OP_ROR: begin
                v    = (a >> s) | (a << (WIDTH - s));
                wide = {v[WIDTH-1], v};
            end
            default: wide = {1'b0, a};
        endcase
        return wide;
    endfunction

    // Per-cycle step size and the shifted working value for this cycle.
    always_comb begin
        step_n    = (int'(rem) < STEP) ? int'(rem) : STEP;
        step_next = {carry_q, acc};
        if (rem != '0) begin
            step_next = shift_by(acc, op_q, step_n);
        end
    end

    // Control FSM and datapath registers; all outputs are registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            rem       <= '0;
            op_q      <= '0;
            carry_q   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        acc     <= operand;
                        // Undefined opcodes degrade to a zero-count pass-through.
                        rem     <= (op > OP_ROR) ? '0 : amount;
                        op_q    <= op;
                        carry_q <= 1'b0;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    if (flush) begin
                        // Cancel: drop the in-flight work, keep the old result.
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (rem != '0) begin
                        {carry_q, acc} <= step_next;
                        rem            <= rem - AW'(step_n);
                    end else begin
                        result    <= acc;
                        carry_out <= carry_q;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_rotate_unit.sv
// Scoreboard bench for shift_rotate_unit (WIDTH=32, STEP=4).
module tb_shift_rotate_unit;

    localparam int W  = 32;
    localparam int ST = 4;
    localparam int A  = $clog2(W);

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] operand;
    logic [A-1:0] amount;
    logic         flush;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry_out;

    typedef struct packed {
        logic [W-1:0] r;
        logic         c;
    } exp_t;

    exp_t         sb[$];
    int           n_checks = 0;
    int           n_fail   = 0;
    logic [W-1:0] last_r   = '0;
    logic         last_c   = 1'b0;

    shift_rotate_unit #(.WIDTH(W), .STEP(ST)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .operand   (operand),
        .amount    (amount),
        .flush     (flush),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Bit-at-a-time reference model.
    task automatic model(input logic [2:0] o, input logic [W-1:0] a, input logic [A-1:0] n,
                         output logic [W-1:0] r, output logic c, output int lat);
        int cnt;
        r   = a;
        c   = 1'b0;
        cnt = (o > 3'b100) ? 0 : int'(n);
        for (int i = 0; i < cnt; i++) begin
            case (o)
                3'b000: begin c = r[W-1]; r = {r[W-2:0], 1'b0};   end
                3'b001: begin c = r[0];   r = {1'b0, r[W-1:1]};   end
                3'b010: begin c = r[0];   r = {r[W-1], r[W-1:1]}; end
                3'b011: begin r = {r[W-2:0], r[W-1]}; c = r[0];   end
                default: begin r = {r[0], r[W-1:1]}; c = r[W-1];  end
            endcase
        end
        lat = (cnt + ST - 1) / ST + 1;
    endtask

    // Monitor: every done pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                check_eq("spurious_done", 64'(done), 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_eq("result", 64'(result), 64'(e.r));
                check_eq("carry_out", 64'(carry_out), 64'(e.c));
                last_r = e.r;
                last_c = e.c;
            end
        end
    end

    // Present one request for one edge; returns the model's expected latency.
    task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [A-1:0] n,
                         input bit push, output int lat);
        exp_t e;
        model(o, a, n, e.r, e.c, lat);
        if (push) sb.push_back(e);
        op      = o;
        operand = a;
        amount  = n;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_eq("busy_after_start", 64'(busy), 64'd1);
    endtask

    // Count edges after the accepting edge until done shows up (bounded).
    task automatic wait_done(input string tag, input int exp_lat);
        int n;
        bit seen;
        seen = 1'b0;
        n    = 0;
        while (!seen && n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (done) seen = 1'b1;
            else      check_eq({tag, "_busy_run"}, 64'(busy), 64'd1);
        end
        check_eq({tag, "_latency"}, 64'(seen ? n : -1), 64'(exp_lat));
        check_eq({tag, "_busy_done"}, 64'(busy), 64'd0);
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] a,
                          input logic [A-1:0] n);
        int lat;
        issue(o, a, n, 1'b1, lat);
        wait_done(tag, lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int           lat;
        logic [A-1:0] amt33;
        logic [5:0]   raw33;

        rst     = 1'b1;
        start   = 1'b0;
        op      = '0;
        operand = '0;
        amount  = '0;
        flush   = 1'b0;
        #2;
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_result", 64'(result), 64'd0);
        check_eq("rst_carry", 64'(carry_out), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed cases with hand-known answers, checked through the model.
        run_op("rol1", 3'b011, 32'h8000_0001, 5'd1);
        check_eq("rol1_const", 64'(result), 64'h0000_0003);
        run_op("ror4", 3'b100, 32'h0000_000F, 5'd4);
        check_eq("ror4_const", 64'(result), 64'hF000_0000);
        run_op("shr4", 3'b001, 32'h0000_000F, 5'd4);
        check_eq("shr4_carry_const", 64'(carry_out), 64'd1);
        run_op("shra31", 3'b010, 32'h8000_0000, 5'd31);
        check_eq("shra31_const", 64'(result), 64'hFFFF_FFFF);
        run_op("shl31", 3'b000, 32'h0000_0001, 5'd31);
        check_eq("shl31_const", 64'(result), 64'h8000_0000);
        run_op("shl0", 3'b000, 32'h1234_5678, 5'd0);
        run_op("undef", 3'b111, 32'h1234_5678, 5'd5);
        check_eq("undef_const", 64'(result), 64'h1234_5678);
        raw33 = 6'd33;
        amt33 = raw33[A-1:0];
        run_op("shl33", 3'b000, 32'h1234_5678, amt33);
        check_eq("shl33_const", 64'(result), 64'h2468_ACF0);

        // Back-to-back: new start presented while done is high.
        issue(3'b001, 32'hDEAD_BEEF, 5'd9, 1'b1, lat);
        wait_done("b2b_a", lat);
        issue(3'b010, 32'hF00D_0001, 5'd13, 1'b1, lat);
        wait_done("b2b_b", lat);

        // A handful of random operations across all modes.
        for (int i = 0; i < 8; i++) begin
            run_op("rand", 3'($urandom_range(0, 4)), W'($urandom), A'($urandom));
        end

        // Ignored start while running, then flush: no done, result kept.
        issue(3'b010, 32'h8000_0000, 5'd31, 1'b0, lat);
        @(posedge clk); #1;
        @(posedge clk); #1;
        op = 3'b011; operand = 32'h0000_0001; amount = 5'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        flush = 1'b1;
        check_eq("flush_busy_before", 64'(busy), 64'd1);
        @(posedge clk); #1;
        flush = 1'b0;
        @(posedge clk); #1;
        check_eq("flush_busy", 64'(busy), 64'd0);
        check_eq("flush_result", 64'(result), 64'(last_r));
        check_eq("flush_carry", 64'(carry_out), 64'(last_c));
        repeat (12) @(posedge clk);
        #1;
        check_eq("flush_idle", 64'(busy), 64'd0);
        check_eq("flush_result_late", 64'(result), 64'(last_r));

        // Asynchronous reset in the middle of a long operation.
        run_op("pre_rst", 3'b011, 32'h0000_00F1, 5'd3);
        issue(3'b011, 32'h1234_5678, 5'd31, 1'b1, lat);
        @(posedge clk);
        #4;
        rst = 1'b1;
        #1;
        sb.delete();
        check_eq("arst_busy", 64'(busy), 64'd0);
        check_eq("arst_done", 64'(done), 64'd0);
        check_eq("arst_result", 64'(result), 64'd0);
        check_eq("arst_carry", 64'(carry_out), 64'd0);
        #10 rst = 1'b0;
        @(posedge clk);
        #1;
        run_op("post_rst", 3'b011, 32'hA5A5_A5A5, 5'd8);
        check_eq("post_rst_const", 64'(result), 64'hA5A5_A5A5);
        check_eq("post_rst_carry", 64'(carry_out), 64'd1);

        repeat (3) @(posedge clk);
        #1;
        check_eq("sb_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_rotate_unit.md
Name: shift_rotate_unit

Overview:
Multi-cycle, parametrised shift/rotate execution unit for the CPU ALU datapath. It supersedes the single-purpose 32-bit rotate-left logic. It supports five shift/rotate modes, a configurable operand width, and a configurable number of bit positions processed per cycle. A start/busy/done handshake lets the control unit stall until the result is valid.

Parameters:
WIDTH, 32, operand/result width in bits; power of two, >= 8
STEP, 4, maximum bit positions shifted per clock; power of two, 1 <= STEP <= WIDTH
AW, $clog2(WIDTH), amount field width (derived; do not override)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
op  input  3  000 SHL, 001 SHR (logical), 010 SHRA (arithmetic), 011 ROL, 100 ROR
operand  input  WIDTH  value to shift (inA)
amount  input  AW  shift count (low AW bits of inB; count is modulo WIDTH)
flush  input  1  synchronous cancel of an in-flight operation
busy  output  1  high while an operation is in flight
done  output  1  one-cycle pulse: result/carry_out valid
result  output  WIDTH  shifted/rotated value; held until next accepted start
carry_out  output  1  last bit shifted or rotated out; held with result

Behaviour:
- Reset (async, rst=1): state=IDLE; busy=0, done=0, result=0, carry_out=0; internal acc, remaining count and latched op cleared. Reset asserted mid-operation aborts it immediately. No done is produced.
- States: IDLE, RUN.
- IDLE: on an edge with start=1, latch operand->acc, amount->rem, op->op_q; go to RUN; busy=1 after that edge. result/carry_out keep their previous values.
- RUN, rem!=0: s=min(rem,STEP); acc shifted by s per op_q; rem-=s; carry_q=last bit leaving acc. Fill rules:
  - SHL and SHR fill with 0.
  - SHRA fills with acc[WIDTH-1].
  - ROL/ROR wrap the exiting bits.
- RUN, rem==0: result<=acc; carry_out<=carry_q; done=1 for exactly one cycle; busy=0; return to IDLE.
- Latency: with k=ceil(amount/STEP) and start sampled at edge 0, done is high after edge k+1. amount=0 gives done after edge 1, result=operand, carry_out=0.
- Back-to-back operation: start may be asserted in the same cycle done is high. It is accepted on that edge because the state is IDLE.
- start while busy=1 is ignored, with no queuing.
- flush=1 in RUN: return to IDLE next edge; busy=0; no done; result/carry_out unchanged. flush in IDLE has no effect. flush has priority over start on the same edge.
- Undefined op (101-111): treated as amount 0. result=operand, carry_out=0, done after edge 1.
- carry_q resets to 0 at every accepted start.
- SHL by n: carry = original bit WIDTH-n.
- SHR/SHRA by n: carry = original bit n-1.
- ROL: carry = result[0].
- ROR: carry = result[WIDTH-1].
- All outputs registered; no combinational path from inputs to outputs.

Test Plan:
1. WIDTH=32, STEP=4. ROL 0x80000001 by 1. Required: result=0x00000003, carry_out=1, done after edge 2, busy high edges 0-1.
2. ROR 0x0000000F by 4. Required: result=0xF0000000, carry_out=1, done after edge 2. SHR 0x0000000F by 4 gives result=0x00000000, carry_out=1.
3. SHRA 0x80000000 by 31. Required: result=0xFFFFFFFF, carry_out=0, done after edge 9 (k=8). SHL 0x00000001 by 31 gives 0x80000000, carry_out=0.
4. SHL 0x12345678 by 0, and op=111 with amount 5. Required in both cases: result=0x12345678, carry_out=0, done after edge 1. Amount input 6'd33 truncated to AW bits acts as 1.
5. During a 31-bit SHRA: assert start with new operands at edge 3, which must be ignored. Then assert flush at edge 4. Required: busy=0 after edge 5, no done pulse, result equal to the previous value.
6. Assert rst asynchronously mid-RUN, between edges. Required: busy, done, result and carry_out drop to 0 immediately. A fresh ROL 0xA5A5A5A5 by 8 after reset gives 0xA5A5A5A5, carry_out=1, done after edge 3.
